// File: rtl/alu_seq_pkg.sv
// Opcode constants, ALU function-select encodings and FSM state type for the ALU op sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpNot = 4'd2;
    localparam logic [3:0] OpShl = 4'd3;
    localparam logic [3:0] OpShr = 4'd4;
    localparam logic [3:0] OpAnd = 4'd5;
    localparam logic [3:0] OpOr  = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpCmp = 4'd8;

    localparam logic [3:0] CtlAdd = 4'd0;
    localparam logic [3:0] CtlSub = 4'd1;
    localparam logic [3:0] CtlNot = 4'd2;
    localparam logic [3:0] CtlShl = 4'd3;
    localparam logic [3:0] CtlShr = 4'd4;
    localparam logic [3:0] CtlAnd = 4'd5;
    localparam logic [3:0] CtlOr  = 4'd6;
    localparam logic [3:0] CtlSlt = 4'd7;
    localparam logic [3:0] CtlCmp = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response/ALU bundle of the ALU op sequencer; slave = sequencer, master = its environment.
interface alu_op_sequencer_if #(
    parameter int unsigned DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          req_use_acc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;
    logic          rsp_err;
    logic [15:0]   rsp_count;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_control;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_count,
        output alu_a, alu_b, alu_control
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_count,
        input  alu_a, alu_b, alu_control
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode to ALU function-select decode with legality flag.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op_i,
    output logic [3:0] ctl_o,
    output logic       legal_o
);

    always_comb begin
        ctl_o   = CtlAdd;
        legal_o = 1'b1;
        case (op_i)
            OpAdd:   ctl_o = CtlAdd;
            OpSub:   ctl_o = CtlSub;
            OpNot:   ctl_o = CtlNot;
            OpShl:   ctl_o = CtlShl;
            OpShr:   ctl_o = CtlShr;
            OpAnd:   ctl_o = CtlAnd;
            OpOr:    ctl_o = CtlOr;
            OpSlt:   ctl_o = CtlSlt;
            OpCmp:   ctl_o = CtlCmp;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through an external ALU and holds the response until taken.
// Optional accumulator operand source enabled by defining ALU_SEQ_ACC_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  seq_bus
);

    seq_state_e    state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_ctl_q, alu_ctl_d;
    logic [DW-1:0] result_q, result_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;

    logic [3:0]    dec_ctl;
    logic          dec_legal;
    logic [DW-1:0] opnd_a;

    alu_op_decode u_decode (
        .op_i    (seq_bus.req_op),
        .ctl_o   (dec_ctl),
        .legal_o (dec_legal)
    );

`ifdef ALU_SEQ_ACC_EN
    logic [DW-1:0] acc_q, acc_d;

    assign opnd_a = seq_bus.req_use_acc ? acc_q : seq_bus.req_a;

    // Accumulator follows every legal-op capture, i.e. the EXEC cycle.
    always_comb begin
        acc_d = acc_q;
        if (state_q == StExec) begin
            acc_d = seq_bus.alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_use_acc;

    assign unused_use_acc = seq_bus.req_use_acc;
    assign opnd_a         = seq_bus.req_a;
`endif

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_ctl_d = alu_ctl_q;
        result_d  = result_q;
        zero_d    = zero_q;
        err_d     = err_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (seq_bus.req_valid) begin
                    if (dec_legal) begin
                        alu_a_d   = opnd_a;
                        alu_b_d   = seq_bus.req_b;
                        alu_ctl_d = dec_ctl;
                        state_d   = StExec;
                    end else begin
                        // Illegal ops skip the ALU and leave its operand registers untouched.
                        result_d = '0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StExec: begin
                result_d = seq_bus.alu_result;
                zero_d   = seq_bus.alu_zero;
                err_d    = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                if (seq_bus.rsp_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctl_q <= CtlAdd;
            result_q  <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ctl_q <= alu_ctl_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    assign seq_bus.req_ready   = (state_q == StIdle);
    assign seq_bus.rsp_valid   = (state_q == StResp);
    assign seq_bus.rsp_result  = result_q;
    assign seq_bus.rsp_zero    = zero_q;
    assign seq_bus.rsp_err     = err_q;
    assign seq_bus.rsp_count   = count_q;
    assign seq_bus.alu_a       = alu_a_q;
    assign seq_bus.alu_b       = alu_b_q;
    assign seq_bus.alu_control = alu_ctl_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
- REQ-001 SHALL use one clock; reset is asynchronous and active-low.
- REQ-002 SHALL have the parameter: DW, 16, width of data words.
- REQ-003 SHALL have the following ports, one per line:
  - clk  in  1  clock, rising edge.
  - rst_n  in  1  async active-low reset.
  - req_valid  in  1  request present.
  - req_ready  out  1  sequencer can accept a request.
  - req_op  in  4  operation code.
  - req_a  in  DW  operand A.
  - req_b  in  DW  operand B.
  - req_use_acc  in  1  replace A with accumulator (macro-dependent).
  - rsp_valid  out  1  response present.
  - rsp_ready  in  1  consumer accepts response.
  - rsp_result  out  DW  captured ALU result.
  - rsp_zero  out  1  captured ALU zero flag.
  - rsp_err  out  1  illegal opcode.
  - rsp_count  out  16  completed-response counter.
  - alu_a  out  DW  ALU operand A.
  - alu_b  out  DW  ALU operand B.
  - alu_control  out  4  ALU function select.
  - alu_result  in  DW  ALU result (combinational from alu_a, alu_b, alu_control).
  - alu_zero  in  1  ALU zero flag.

Function
- REQ-004 SHALL implement a state machine with states IDLE, EXEC and RESP.
- REQ-005 SHALL drive req_ready=1 only in IDLE.
- REQ-006 Opcode map to alu_control SHALL be:
  - 0 ADD->0, 1 SUB->1, 2 NOT->2, 3 SHL->3, 4 SHR->4.
  - 5 AND->5, 6 OR->6, 7 SLT->7, 8 CMP->8.
  - Opcodes 9-15 are illegal.
- REQ-007 On a legal handshake (IDLE, req_valid & req_ready) at edge E0, the block SHALL register alu_a, alu_b and alu_control, and SHALL go to EXEC.
- REQ-008 In EXEC, the block SHALL capture alu_result and alu_zero into rsp_result and rsp_zero at edge E1, set rsp_err=0, and go to RESP; rsp_valid SHALL be high from E1.
- REQ-009 On an illegal opcode handshake at E0, the block SHALL go directly to RESP with rsp_err=1, rsp_result=0 and rsp_zero=0; alu_a, alu_b and alu_control SHALL keep their previous values.
- REQ-010 In RESP, rsp_valid, rsp_result, rsp_zero and rsp_err SHALL hold stable until rsp_ready=1; on that edge the block SHALL return to IDLE and drop rsp_valid.
- REQ-011 Minimum legal-op turnaround SHALL be 3 cycles; a new request SHALL NOT be accepted in the same cycle as a response handshake.
- REQ-012 rsp_count SHALL increment by 1 on every response handshake, including errors, and SHALL wrap from 0xFFFF to 0x0000.
- REQ-013 req_* inputs SHALL be ignored outside IDLE.
- REQ-014 rsp_ready SHALL be ignored outside RESP.

Reset
- REQ-015 Reset SHALL force state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_count=0, alu_a=0, alu_b=0 and alu_control=0; req_ready SHALL then be 1.
- REQ-016 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing a response and without incrementing the counter.

Configuration
- REQ-017 With ALU_SEQ_ACC_EN defined, the block SHALL contain a DW-bit accumulator:
  - The accumulator resets to 0.
  - It loads rsp_result at every legal-op capture (E1).
  - When req_use_acc=1 at acceptance, alu_a SHALL be loaded from the accumulator instead of req_a.
- REQ-018 Without ALU_SEQ_ACC_EN, no accumulator SHALL exist and req_use_acc SHALL be ignored.

Structure
- REQ-019 Package alu_seq_pkg SHALL hold the opcode constants, the alu_control encodings and the state enum typedef.
- REQ-020 Opcode-to-alu_control decoding and the legality check SHALL live in one combinational sub-module, alu_op_decode.
- REQ-021 The ALU itself is external and SHALL NOT be instantiated inside this block.

Verification (bench models the ALU combinationally)
- REQ-022 The bench SHALL cover the following scenarios:
  - ADD a=0x0003, b=0x0004, rsp_ready=1 -> rsp_valid 2 edges after acceptance, rsp_result=0x0007, rsp_zero=0, rsp_err=0, rsp_count=1.
  - SUB a=0x0005, b=0x0005 -> rsp_result=0x0000, rsp_zero=1.
  - CMP a=0x1234, b=0x1234 -> rsp_result=0x0009.
  - CMP a=0x1234, b=0x1235 -> rsp_result=0x0007.
  - Illegal op 0xA -> rsp_valid 1 edge after acceptance, rsp_err=1, rsp_result=0, alu_control unchanged.
  - rsp_ready held 0 for 5 cycles -> response outputs stable, req_ready=0 throughout, count increments only at the handshake.
  - rst_n pulsed low during EXEC -> all outputs at reset values, no response, rsp_count=0.
  - 65536 responses -> rsp_count wraps to 0x0000.
  - With ALU_SEQ_ACC_EN: ADD 2+3, then ADD with req_use_acc=1 and b=0x0004 -> second rsp_result=0x0009.
